// File: rtl/led_disp_pkg.sv
// rtl/led_disp_pkg.sv - display constants, state encoding and display-state selection
package led_disp_pkg;

    localparam logic [3:0]  CHAR_BLANK      = 4'hC;
    localparam logic [15:0] ERR_FRAME_WORD  = 16'hEEE1;
    localparam logic [15:0] ERR_PARITY_WORD = 16'hEEE2;
    localparam logic [15:0] IDLE_WORD       = 16'hCCCC;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SHOW   = 2'b01;
    localparam logic [1:0] ST_SCROLL = 2'b10;
    localparam logic [1:0] ST_ERROR  = 2'b11;

    function automatic logic [1:0] select_state(input logic [4:0] len, input logic scroll_en);
        if (len == 5'd0) begin
            return ST_IDLE;
        end
        if ((len <= 5'd4) || !scroll_en) begin
            return ST_SHOW;
        end
        return ST_SCROLL;
    endfunction

endpackage

// File: rtl/led_word_scheduler_if.sv
// rtl/led_word_scheduler_if.sv - byte stream from the UART receiver into the scheduler
interface led_word_scheduler_if;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ferror;
    logic       rx_perror;
    logic       rx_ready;

    modport master (output rx_valid, rx_data, rx_ferror, rx_perror, input rx_ready);
    modport slave  (input rx_valid, rx_data, rx_ferror, rx_perror, output rx_ready);

endinterface

// File: rtl/nibble_msg_buffer.sv
// rtl/nibble_msg_buffer.sv - 16-nibble message store with a circular 4-nibble window
module nibble_msg_buffer
    import led_disp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        clr,
    input  logic [3:0]  ptr,
    output logic [4:0]  len,
    output logic [4:0]  len_nx,
    output logic        full,
    output logic [15:0] window
);

    logic [3:0] mem    [16];
    logic [3:0] mem_nx [16];
    logic [4:0] pos;
    logic       wr_ok;

    assign full   = (len == 5'd16);
    assign wr_ok  = wr_en && !full && !clr;
    assign len_nx = clr ? 5'd0 : (wr_ok ? len + 5'd2 : len);

    always_comb begin
        mem_nx = mem;
        if (wr_ok) begin
            mem_nx[len[3:0]]        = wr_data[7:4];
            mem_nx[len[3:0] + 4'd1] = wr_data[3:0];
        end
    end

    // Window is built from the post-write contents so the registered word sees a byte in the same edge it lands.
    always_comb begin
        window = '0;
        pos    = '0;
        for (int i = 0; i < 4; i++) begin
            pos = {1'b0, ptr} + 5'(i);
            if (pos >= len_nx) begin
                pos = pos - len_nx;
            end
            window[15 - 4 * i -: 4] = (5'(i) >= len_nx) ? CHAR_BLANK : mem_nx[pos[3:0]];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len <= '0;
        end else begin
            len <= len_nx;
        end
    end

    always_ff @(posedge clk) begin
        mem <= mem_nx;
    end

endmodule

// File: rtl/led_word_scheduler.sv
// rtl/led_word_scheduler.sv - sequences the 16-bit word shown on the four-digit display
module led_word_scheduler
    import led_disp_pkg::*;
#(
    parameter int SCROLL_CYCLES   = 50_000_000,
    parameter int ERR_HOLD_CYCLES = 100_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    led_word_scheduler_if.slave  rx,
    input  logic                 scroll_en,
    input  logic                 clear,
    output logic [15:0]          word,
    output logic                 overflow,
    output logic [1:0]           disp_state
);

    localparam int SC_W = $clog2(SCROLL_CYCLES);
    localparam int EH_W = $clog2(ERR_HOLD_CYCLES);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCROLL_CYCLES - 1);
    localparam logic [EH_W-1:0] EH_LAST = EH_W'(ERR_HOLD_CYCLES - 1);

    logic [1:0]      state, state_nx, tgt;
    logic [3:0]      ptr, ptr_nx;
    logic [SC_W-1:0] scroll_t, scroll_t_nx;
    logic [EH_W-1:0] hold_t, hold_t_nx;
    logic [15:0]     err_word, err_word_nx;
    logic [15:0]     word_nx;
    logic            overflow_nx;
    logic            rx_ready_q;
    logic [4:0]      len, len_nx;
    logic            full;
    logic [15:0]     window;
    logic            clean, bad;

    assign clean = rx.rx_valid && !rx.rx_ferror && !rx.rx_perror;
    assign bad   = rx.rx_valid && (rx.rx_ferror || rx.rx_perror);

    nibble_msg_buffer u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (clean),
        .wr_data (rx.rx_data),
        .clr     (clear),
        .ptr     (ptr_nx),
        .len     (len),
        .len_nx  (len_nx),
        .full    (full),
        .window  (window)
    );

    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        scroll_t_nx = scroll_t;
        hold_t_nx   = hold_t;
        err_word_nx = err_word;
        overflow_nx = overflow;
        tgt         = select_state(len_nx, scroll_en);
        if (clear) begin
            state_nx    = ST_IDLE;
            ptr_nx      = '0;
            scroll_t_nx = '0;
            hold_t_nx   = '0;
            overflow_nx = 1'b0;
        end else begin
            if (clean && full) begin
                overflow_nx = 1'b1;
            end
            if (bad) begin
                state_nx    = ST_ERROR;
                hold_t_nx   = '0;
                err_word_nx = rx.rx_ferror ? ERR_FRAME_WORD : ERR_PARITY_WORD;
            end else if (state == ST_ERROR) begin
                if (hold_t == EH_LAST) begin
                    state_nx    = tgt;
                    ptr_nx      = '0;
                    scroll_t_nx = '0;
                    hold_t_nx   = '0;
                end else begin
                    hold_t_nx = hold_t + 1'b1;
                end
            end else begin
                state_nx = tgt;
                if (tgt != ST_SCROLL) begin
                    ptr_nx      = '0;
                    scroll_t_nx = '0;
                end else if (state != ST_SCROLL) begin
                    scroll_t_nx = '0;
                end else if (scroll_t == SC_LAST) begin
                    // Step modulus is the length before this cycle's append.
                    scroll_t_nx = '0;
                    ptr_nx      = (({1'b0, ptr} + 5'd1) >= len) ? 4'd0 : ptr + 4'd1;
                end else begin
                    scroll_t_nx = scroll_t + 1'b1;
                end
            end
        end
        case (state_nx)
            ST_ERROR: word_nx = err_word_nx;
            ST_IDLE:  word_nx = IDLE_WORD;
            default:  word_nx = window;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            scroll_t   <= '0;
            hold_t     <= '0;
            err_word   <= ERR_FRAME_WORD;
            overflow   <= 1'b0;
            word       <= IDLE_WORD;
            rx_ready_q <= 1'b1;
        end else begin
            state      <= state_nx;
            ptr        <= ptr_nx;
            scroll_t   <= scroll_t_nx;
            hold_t     <= hold_t_nx;
            err_word   <= err_word_nx;
            overflow   <= overflow_nx;
            word       <= word_nx;
            rx_ready_q <= (len_nx <= 5'd14);
        end
    end

    assign rx.rx_ready = rx_ready_q;
    assign disp_state  = state;

endmodule
